// File: rtl/lsu_mem_pkg.sv
// Shared encodings for the load/store unit: access sizes, exception causes and FSM states.
package lsu_mem_pkg;

   localparam logic [1:0] LSU_SIZE_B = 2'b00;
   localparam logic [1:0] LSU_SIZE_H = 2'b01;
   localparam logic [1:0] LSU_SIZE_W = 2'b10;
   localparam logic [1:0] LSU_SIZE_D = 2'b11;

   localparam logic [1:0] LSU_EXC_NONE    = 2'b00;
   localparam logic [1:0] LSU_EXC_MIS_LD  = 2'b01;
   localparam logic [1:0] LSU_EXC_MIS_ST  = 2'b10;
   localparam logic [1:0] LSU_EXC_TIMEOUT = 2'b11;

   localparam logic [1:0] LSU_ST_IDLE = 2'b00;
   localparam logic [1:0] LSU_ST_REQ  = 2'b01;
   localparam logic [1:0] LSU_ST_RSP  = 2'b10;

   // A dword access is only legal on a 64-bit bus, otherwise it always counts as misaligned.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] low,
                                          input logic dword_ok);
      case (size)
         LSU_SIZE_B: is_misaligned = 1'b0;
         LSU_SIZE_H: is_misaligned = low[0];
         LSU_SIZE_W: is_misaligned = |low[1:0];
         default:    is_misaligned = !dword_ok || (|low);
      endcase
   endfunction

endpackage

// File: rtl/lsu_mem_align.sv
// Combinational lane logic: misalign check, byte enables, store replication, load extract/extend.
module lsu_mem_align
   import lsu_mem_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [1:0]                   chk_size,
   input  logic [2:0]                   chk_low,
   output logic                         misaligned,
   input  logic [1:0]                   size,
   input  logic                         uns,
   input  logic [$clog2(XLEN/8)-1:0]    off,
   input  logic [XLEN-1:0]              wdata,
   input  logic [XLEN-1:0]              rdata,
   output logic [XLEN/8-1:0]            be,
   output logic [XLEN-1:0]              bus_wdata,
   output logic [XLEN-1:0]              load_data
);
   localparam int NB = XLEN / 8;

   logic [XLEN-1:0] shifted;

   assign misaligned = is_misaligned(chk_size, chk_low, XLEN == 64);
   assign shifted    = rdata >> {off, 3'b000};

   always_comb begin
      be        = '1;
      bus_wdata = wdata;
      load_data = shifted;
      case (size)
         LSU_SIZE_B: begin
            be        = NB'(1) << off;
            bus_wdata = {NB{wdata[7:0]}};
            load_data = uns ? XLEN'(shifted[7:0]) : XLEN'($signed(shifted[7:0]));
         end
         LSU_SIZE_H: begin
            be        = NB'(3) << off;
            bus_wdata = {(NB/2){wdata[15:0]}};
            load_data = uns ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
         end
         LSU_SIZE_W: begin
            be        = NB'(15) << off;
            bus_wdata = {(NB/4){wdata[31:0]}};
            load_data = uns ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/lsu_mem.sv
// Load/store unit: ALU results pass straight through; memory ops run a req/gnt/rvalid bus FSM
// with a timeout, stalling upstream until the access completes.
module lsu_mem
   import lsu_mem_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int REG_ADDR_W  = 5,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rd_we_i,
   input  logic [XLEN-1:0]       rd_data_i,
   input  logic [REG_ADDR_W-1:0] rd_addr_i,
   input  logic                  mem_req_i,
   input  logic                  mem_we_i,
   input  logic [1:0]            mem_size_i,
   input  logic                  mem_unsigned_i,
   input  logic [XLEN-1:0]       mem_addr_i,
   input  logic [XLEN-1:0]       mem_wdata_i,
   output logic                  rd_we_o,
   output logic [XLEN-1:0]       rd_data_o,
   output logic [REG_ADDR_W-1:0] rd_addr_o,
   output logic                  stall_o,
   output logic                  exc_o,
   output logic [1:0]            exc_cause_o,
   output logic                  dbus_req_o,
   output logic                  dbus_we_o,
   output logic [XLEN/8-1:0]     dbus_be_o,
   output logic [XLEN-1:0]       dbus_addr_o,
   output logic [XLEN-1:0]       dbus_wdata_o,
   input  logic                  dbus_gnt_i,
   input  logic                  dbus_rvalid_i,
   input  logic [XLEN-1:0]       dbus_rdata_i
);
   localparam int OFF_W = $clog2(XLEN / 8);
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [1:0]            state;
   logic [CNT_W-1:0]      cnt;
   logic [XLEN-1:0]       lat_addr;
   logic [XLEN-1:0]       lat_wdata;
   logic                  lat_we;
   logic [1:0]            lat_size;
   logic                  lat_uns;
   logic [REG_ADDR_W-1:0] lat_rd;

   logic                  misaligned;
   logic [XLEN/8-1:0]     be;
   logic [XLEN-1:0]       bus_wdata;
   logic [XLEN-1:0]       load_data;
   logic                  idle, issue, complete, timeout;

   lsu_mem_align #(.XLEN(XLEN)) u_align (
      .chk_size   (mem_size_i),
      .chk_low    (mem_addr_i[2:0]),
      .misaligned (misaligned),
      .size       (lat_size),
      .uns        (lat_uns),
      .off        (lat_addr[OFF_W-1:0]),
      .wdata      (lat_wdata),
      .rdata      (dbus_rdata_i),
      .be         (be),
      .bus_wdata  (bus_wdata),
      .load_data  (load_data)
   );

   assign idle     = (state == LSU_ST_IDLE);
   assign issue    = idle && mem_req_i && !misaligned;
   assign complete = (state == LSU_ST_RSP) && dbus_rvalid_i;
   assign timeout  = !idle && !complete && (cnt == CNT_W'(TIMEOUT_CYC));

   // Outputs are held at zero while reset is asserted so an in-flight response cannot leak out.
   always_comb begin
      rd_we_o      = 1'b0;
      rd_data_o    = '0;
      rd_addr_o    = '0;
      stall_o      = 1'b0;
      exc_o        = 1'b0;
      exc_cause_o  = LSU_EXC_NONE;
      dbus_req_o   = 1'b0;
      dbus_we_o    = 1'b0;
      dbus_be_o    = '0;
      dbus_addr_o  = '0;
      dbus_wdata_o = '0;
      if (!rst) begin
         if (idle) begin
            stall_o = issue;
            if (!mem_req_i) begin
               rd_we_o   = rd_we_i;
               rd_data_o = rd_data_i;
               rd_addr_o = rd_addr_i;
            end else if (misaligned) begin
               exc_o       = 1'b1;
               exc_cause_o = mem_we_i ? LSU_EXC_MIS_ST : LSU_EXC_MIS_LD;
            end
         end else begin
            stall_o = !complete && !timeout;
            if (complete && !lat_we) begin
               rd_we_o   = (lat_rd != '0);
               rd_data_o = load_data;
               rd_addr_o = lat_rd;
            end
            if (timeout) begin
               exc_o       = 1'b1;
               exc_cause_o = LSU_EXC_TIMEOUT;
            end
         end
         if (state == LSU_ST_REQ) begin
            dbus_req_o   = 1'b1;
            dbus_we_o    = lat_we;
            dbus_be_o    = be;
            dbus_addr_o  = {lat_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
            dbus_wdata_o = bus_wdata;
         end
      end
   end

   // The counter runs from the first REQ cycle and is cleared whenever the FSM returns to IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= LSU_ST_IDLE;
         cnt       <= '0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_we    <= 1'b0;
         lat_size  <= '0;
         lat_uns   <= 1'b0;
         lat_rd    <= '0;
      end else begin
         case (state)
            LSU_ST_IDLE: begin
               cnt <= '0;
               if (issue) begin
                  state     <= LSU_ST_REQ;
                  lat_addr  <= mem_addr_i;
                  lat_wdata <= mem_wdata_i;
                  lat_we    <= mem_we_i;
                  lat_size  <= mem_size_i;
                  lat_uns   <= mem_unsigned_i;
                  lat_rd    <= rd_addr_i;
               end
            end
            LSU_ST_REQ: begin
               if (timeout) begin
                  state <= LSU_ST_IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
                  if (dbus_gnt_i) state <= LSU_ST_RSP;
               end
            end
            LSU_ST_RSP: begin
               if (complete || timeout) begin
                  state <= LSU_ST_IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= LSU_ST_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem.sv
// Directed self-checking bench for lsu_mem (XLEN=32, short timeout so the timeout path is cheap to hit).
module tb_lsu_mem;
   localparam int XLEN = 32;
   localparam int RW   = 5;

   logic            clk = 1'b0;
   logic            rst;
   logic            rd_we_i;
   logic [XLEN-1:0] rd_data_i;
   logic [RW-1:0]   rd_addr_i;
   logic            mem_req_i, mem_we_i, mem_unsigned_i;
   logic [1:0]      mem_size_i;
   logic [XLEN-1:0] mem_addr_i, mem_wdata_i;
   logic            rd_we_o;
   logic [XLEN-1:0] rd_data_o;
   logic [RW-1:0]   rd_addr_o;
   logic            stall_o, exc_o;
   logic [1:0]      exc_cause_o;
   logic            dbus_req_o, dbus_we_o;
   logic [3:0]      dbus_be_o;
   logic [XLEN-1:0] dbus_addr_o, dbus_wdata_o;
   logic            dbus_gnt_i, dbus_rvalid_i;
   logic [XLEN-1:0] dbus_rdata_i;

   int testCount = 0;
   int failCount = 0;

   logic            capRdWe, capStall, capBusReq, capBusWe;
   logic [XLEN-1:0] capRdData, capBusAddr, capBusWdata;
   logic [RW-1:0]   capRdAddr;
   logic [3:0]      capBe;

   lsu_mem #(.XLEN(XLEN), .REG_ADDR_W(RW), .TIMEOUT_CYC(4)) dut (
      .clk(clk), .rst(rst),
      .rd_we_i(rd_we_i), .rd_data_i(rd_data_i), .rd_addr_i(rd_addr_i),
      .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_size_i(mem_size_i),
      .mem_unsigned_i(mem_unsigned_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
      .rd_we_o(rd_we_o), .rd_data_o(rd_data_o), .rd_addr_o(rd_addr_o),
      .stall_o(stall_o), .exc_o(exc_o), .exc_cause_o(exc_cause_o),
      .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_be_o(dbus_be_o),
      .dbus_addr_o(dbus_addr_o), .dbus_wdata_o(dbus_wdata_o),
      .dbus_gnt_i(dbus_gnt_i), .dbus_rvalid_i(dbus_rvalid_i), .dbus_rdata_i(dbus_rdata_i)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      testCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic req, input logic we, input logic [1:0] size,
                                input logic uns, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [4:0] rdAddr);
      mem_req_i      = req;
      mem_we_i       = we;
      mem_size_i     = size;
      mem_unsigned_i = uns;
      mem_addr_i     = addr;
      mem_wdata_i    = wdata;
      rd_addr_i      = rdAddr;
      rd_we_i        = 1'b0;
   endtask

   // Issue an aligned access, grant in the first REQ cycle, respond in the following cycle.
   task automatic runAccess(input string tag, input logic we, input logic [1:0] size,
                            input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [4:0] rdAddr, input logic [31:0] rdata);
      applyStimulus(1'b1, we, size, uns, addr, wdata, rdAddr);
      #1;
      checkOutput({tag, "_issue_stall"}, 64'(stall_o), 64'd1);
      @(negedge clk);
      #1;
      capBusReq   = dbus_req_o;
      capBusWe    = dbus_we_o;
      capBe       = dbus_be_o;
      capBusAddr  = dbus_addr_o;
      capBusWdata = dbus_wdata_o;
      dbus_gnt_i  = 1'b1;
      @(negedge clk);
      dbus_gnt_i    = 1'b0;
      dbus_rvalid_i = 1'b1;
      dbus_rdata_i  = rdata;
      #1;
      capRdWe   = rd_we_o;
      capRdData = rd_data_o;
      capRdAddr = rd_addr_o;
      capStall  = stall_o;
      @(negedge clk);
      dbus_rvalid_i = 1'b0;
      mem_req_i     = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0);
      rd_data_i     = '0;
      dbus_gnt_i    = 1'b0;
      dbus_rvalid_i = 1'b0;
      dbus_rdata_i  = '0;
      @(negedge clk);
      @(negedge clk);
      #1;
      checkOutput("rst_stall", 64'(stall_o), 64'd0);
      checkOutput("rst_req", 64'(dbus_req_o), 64'd0);
      checkOutput("rst_exc", 64'(exc_o), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // ALU pass-through
      rd_we_i   = 1'b1;
      rd_addr_i = 5'd5;
      rd_data_i = 32'h1234;
      #1;
      checkOutput("alu_we", 64'(rd_we_o), 64'd1);
      checkOutput("alu_data", 64'(rd_data_o), 64'h1234);
      checkOutput("alu_addr", 64'(rd_addr_o), 64'd5);
      checkOutput("alu_stall", 64'(stall_o), 64'd0);
      @(negedge clk);

      runAccess("lb", 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 5'd7, 32'h80FF_0000);
      checkOutput("lb_busreq", 64'(capBusReq), 64'd1);
      checkOutput("lb_busaddr", 64'(capBusAddr), 64'h100);
      checkOutput("lb_we", 64'(capRdWe), 64'd1);
      checkOutput("lb_data", 64'(capRdData), 64'hFFFF_FF80);
      checkOutput("lb_addr", 64'(capRdAddr), 64'd7);
      checkOutput("lb_stall", 64'(capStall), 64'd0);

      runAccess("lbu", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 5'd7, 32'h80FF_0000);
      checkOutput("lbu_data", 64'(capRdData), 64'h80);

      runAccess("lh", 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 5'd3, 32'h8123_4567);
      checkOutput("lh_data", 64'(capRdData), 64'hFFFF_8123);
      runAccess("lhu", 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 5'd3, 32'h8123_4567);
      checkOutput("lhu_data", 64'(capRdData), 64'h8123);

      runAccess("lw0", 1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 5'd0, 32'hDEAD_BEEF);
      checkOutput("lw_x0_we", 64'(capRdWe), 64'd0);

      runAccess("sh", 1'b1, 2'b01, 1'b0, 32'h102, 32'h0000_ABCD, 5'd0, 32'h0);
      checkOutput("sh_be", 64'(capBe), 64'hC);
      checkOutput("sh_wdata", 64'(capBusWdata), 64'hABCD_ABCD);
      checkOutput("sh_addr", 64'(capBusAddr), 64'h100);
      checkOutput("sh_buswe", 64'(capBusWe), 64'd1);
      checkOutput("sh_rdwe", 64'(capRdWe), 64'd0);
      checkOutput("sh_stall", 64'(capStall), 64'd0);

      runAccess("sb", 1'b1, 2'b00, 1'b0, 32'h101, 32'h0000_005A, 5'd0, 32'h0);
      checkOutput("sb_be", 64'(capBe), 64'h2);
      checkOutput("sb_wdata", 64'(capBusWdata), 64'h5A5A_5A5A);

      // Misaligned accesses, including a dword on a 32-bit bus
      applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 5'd3);
      #1;
      checkOutput("mis_lw_exc", 64'(exc_o), 64'd1);
      checkOutput("mis_lw_cause", 64'(exc_cause_o), 64'd1);
      checkOutput("mis_lw_stall", 64'(stall_o), 64'd0);
      checkOutput("mis_lw_rdwe", 64'(rd_we_o), 64'd0);
      @(negedge clk);
      mem_req_i = 1'b0;
      #1;
      checkOutput("mis_lw_noreq", 64'(dbus_req_o), 64'd0);
      @(negedge clk);
      applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 32'h102, 32'h0, 5'd0);
      #1;
      checkOutput("mis_sw_cause", 64'(exc_cause_o), 64'd2);
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 5'd3);
      #1;
      checkOutput("mis_ld32_exc", 64'(exc_o), 64'd1);
      @(negedge clk);
      mem_req_i = 1'b0;
      #1;
      checkOutput("mis_ld32_noreq", 64'(dbus_req_o), 64'd0);
      @(negedge clk);

      // Timeout: grant never arrives
      applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 5'd4);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         checkOutput("to_wait_stall", 64'(stall_o), 64'd1);
         checkOutput("to_wait_exc", 64'(exc_o), 64'd0);
      end
      @(negedge clk);
      #1;
      checkOutput("to_exc", 64'(exc_o), 64'd1);
      checkOutput("to_cause", 64'(exc_cause_o), 64'd3);
      checkOutput("to_stall", 64'(stall_o), 64'd0);
      checkOutput("to_rdwe", 64'(rd_we_o), 64'd0);
      @(negedge clk);
      mem_req_i     = 1'b0;
      dbus_rvalid_i = 1'b1;
      dbus_rdata_i  = 32'h1111_2222;
      #1;
      checkOutput("to_late_rdwe", 64'(rd_we_o), 64'd0);
      checkOutput("to_late_req", 64'(dbus_req_o), 64'd0);
      checkOutput("to_late_exc", 64'(exc_o), 64'd0);
      @(negedge clk);
      dbus_rvalid_i = 1'b0;

      // Reset while waiting for the response
      applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 5'd9);
      @(negedge clk);
      dbus_gnt_i = 1'b1;
      @(negedge clk);
      dbus_gnt_i = 1'b0;
      #1;
      checkOutput("rsp_stall", 64'(stall_o), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst           = 1'b0;
      mem_req_i     = 1'b0;
      dbus_rvalid_i = 1'b1;
      dbus_rdata_i  = 32'h0000_0055;
      #1;
      checkOutput("rrst_rdwe", 64'(rd_we_o), 64'd0);
      checkOutput("rrst_req", 64'(dbus_req_o), 64'd0);
      checkOutput("rrst_stall", 64'(stall_o), 64'd0);
      checkOutput("rrst_exc", 64'(exc_o), 64'd0);
      @(negedge clk);
      dbus_rvalid_i = 1'b0;

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
